vdp_fsm: RTL and testbench

- Pixel-rate fetch/render engine for a TMS9918-style VDP in Graphics I mode. It sits between the VGA timing generator (sync/active inputs) and the colour/palette output stage.
- Per 8-pixel tile it issues VRAM DMA reads for the name, pattern and colour bytes. It serialises the pattern into 4-bit colour indices.
- All timing inputs are delayed so that they stay aligned with `color_out`.

---
 rtl/vdp_pkg.sv | 30 +++
 rtl/vdp_delay_line.sv | 28 ++
 rtl/vdp_fsm.sv | 164 ++++++++++++++++
 tb/tb_vdp_fsm.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared constants and types for the Graphics I fetch/render engine.
// Slot encodings follow the one-hot ring counter; PIPE_DLY is input-to-output lag.
// No flow control: everything runs at one pixel per pxclk.
package vdp_pkg;

  localparam logic [7:0] SLOT_IDLE    = 8'h01;
  localparam logic [7:0] SLOT_NAME    = 8'h02;
  localparam logic [7:0] SLOT_NAME_LD = 8'h04;
  localparam logic [7:0] SLOT_PAT     = 8'h08;
  localparam logic [7:0] SLOT_COL     = 8'h10;
  localparam logic [7:0] SLOT_COL_LD  = 8'h20;
  localparam logic [7:0] SLOT_LOAD    = 8'h80;

  localparam logic [2:0] GFX1 = 3'd1;

  // Timing inputs to color_out/*_out: 8-stage delay line plus output register.
  localparam int PIPE_DLY = 9;

  // The seven timing strobes travel together through the delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vid_active;
    logic bdr_active;
    logic last_pixel;
    logic col_last;
    logic row_last;
  } timing_t;

endpackage

// File: rtl/vdp_delay_line.sv
// Parameterised shift register used to align timing strobes with pixel data.
// Latency: DEPTH cycles from din_i to dout_o.
// No backpressure: advances every clock.
module vdp_delay_line #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift every cycle; asynchronous clear of every stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vdp_fsm.sv
// TMS9918-style Graphics I fetch/render engine: 8-slot ring drives VRAM reads, pattern shifter makes pixels.
// Latency: color_out and all *_out lag their inputs by exactly 9 pxclk.
// No backpressure: VRAM must answer one cycle after each read tick. Option macro VDP_TRANSPARENT_EN.
module vdp_fsm
  import vdp_pkg::*;
#(
  parameter  int VRAM_SIZE       = 8192,
  localparam int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
  input  logic                       pxclk,
  input  logic                       reset,
  input  logic [9:0]                 px_row,
  input  logic [2:0]                 vdp_mode,
  input  logic                       vdp_blank,
  input  logic                       vdp_smag,
  input  logic                       vdp_ssiz,
  input  logic [3:0]                 vdp_name_base,
  input  logic [7:0]                 vdp_color_base,
  input  logic [2:0]                 vdp_pattern_base,
  input  logic [6:0]                 vdp_sprite_att_base,
  input  logic [2:0]                 vdp_sprite_pat_base,
  input  logic [3:0]                 vdp_fg_color,
  input  logic [3:0]                 vdp_bg_color,
  output logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
  output logic                       vdp_dma_rd_tick,
  input  logic [7:0]                 vram_dout,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic                       vid_active,
  input  logic                       bdr_active,
  input  logic                       last_pixel,
  input  logic                       col_last,
  input  logic                       row_last,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       vid_active_out,
  output logic                       bdr_active_out,
  output logic                       last_pixel_out,
  output logic                       col_last_out,
  output logic                       row_last_out,
  output logic [3:0]                 color_out
);

  logic [7:0]                 ring_q, ring_d;
  logic [4:0]                 col_q, col_d;
  logic [7:0]                 name_q, pat_q, clr_q;
  logic [7:0]                 shift_q, latch_q;
  logic [VRAM_ADDR_WIDTH-1:0] addr_q, addr_sel;
  logic                       rd_slot, fetch_en;
  logic [3:0]                 nib, pix, color_d, color_q;
  timing_t                    tin, tdly, tout_q;

  // Sprite/text controls and the top row bits are not used by Graphics I.
  logic unused_inputs;
  assign unused_inputs = ^{px_row[9:8], vdp_smag, vdp_ssiz, vdp_sprite_att_base,
                           vdp_sprite_pat_base, vdp_fg_color};

  assign tin = {hsync, vsync, vid_active, bdr_active, last_pixel, col_last, row_last};

  vdp_delay_line #(
    .WIDTH($bits(timing_t)),
    .DEPTH(PIPE_DLY - 1)
  ) u_dly (
    .clk_i (pxclk),
    .rst_ni(reset),
    .din_i (tin),
    .dout_o(tdly)
  );

  assign fetch_en = vid_active && !vdp_blank && (vdp_mode == GFX1);

  // Ring rotates through the tile's 8 slots; column advances on the last slot.
  always_comb begin
    ring_d = SLOT_IDLE;
    col_d  = '0;
    if (vid_active) begin
      ring_d = {ring_q[6:0], ring_q[7]};
      col_d  = (ring_q == SLOT_LOAD) ? col_q + 5'd1 : col_q;
    end
  end

  // Address for the current read slot; bases are sampled live so changes land on the next slot.
  always_comb begin
    rd_slot  = 1'b0;
    addr_sel = addr_q;
    case (ring_q)
      SLOT_NAME: begin
        rd_slot  = 1'b1;
        addr_sel = VRAM_ADDR_WIDTH'({vdp_name_base, px_row[7:3], col_q});
      end
      SLOT_PAT: begin
        rd_slot  = 1'b1;
        addr_sel = VRAM_ADDR_WIDTH'({vdp_pattern_base, name_q, px_row[2:0]});
      end
      SLOT_COL: begin
        rd_slot  = 1'b1;
        addr_sel = VRAM_ADDR_WIDTH'({vdp_color_base, 1'b0, name_q[7:3]});
      end
      default: ;
    endcase
  end

  assign vdp_dma_rd_tick = rd_slot && fetch_en;
  assign vdp_dma_addr    = vdp_dma_rd_tick ? addr_sel : addr_q;

  assign nib = shift_q[7] ? latch_q[7:4] : latch_q[3:0];
`ifdef VDP_TRANSPARENT_EN
  assign pix = (nib == 4'd0) ? vdp_bg_color : nib;
`else
  assign pix = nib;
`endif

  // Output colour priority: active pixel, then backdrop for blank/other modes and border, else black.
  always_comb begin
    color_d = 4'd0;
    if (tdly.vid_active) begin
      color_d = (!vdp_blank && (vdp_mode == GFX1)) ? pix : vdp_bg_color;
    end else if (tdly.bdr_active) begin
      color_d = vdp_bg_color;
    end
  end

  // Slot sequencer, fetch registers, pixel shifter and registered outputs.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      ring_q  <= SLOT_IDLE;
      col_q   <= '0;
      name_q  <= '0;
      pat_q   <= '0;
      clr_q   <= '0;
      shift_q <= '0;
      latch_q <= '0;
      addr_q  <= '0;
      color_q <= '0;
      tout_q  <= '0;
    end else begin
      ring_q <= ring_d;
      col_q  <= col_d;
      addr_q <= vdp_dma_addr;
      if (ring_q == SLOT_NAME_LD) name_q <= vram_dout;
      if (ring_q == SLOT_COL)     pat_q  <= vram_dout;
      if (ring_q == SLOT_COL_LD)  clr_q  <= vram_dout;
      // A partial tile cut short by vid_active falling never reaches the load slot.
      if (vid_active && ring_q == SLOT_LOAD) begin
        shift_q <= pat_q;
        latch_q <= clr_q;
      end else begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
      color_q <= color_d;
      tout_q  <= tdly;
    end
  end

  assign color_out      = color_q;
  assign hsync_out      = tout_q.hsync;
  assign vsync_out      = tout_q.vsync;
  assign vid_active_out = tout_q.vid_active;
  assign bdr_active_out = tout_q.bdr_active;
  assign last_pixel_out = tout_q.last_pixel;
  assign col_last_out   = tout_q.col_last;
  assign row_last_out   = tout_q.row_last;

endmodule

// File: tb/tb_vdp_fsm.sv
// Directed bench for vdp_fsm: reset, tile fetch addresses, pixel colours, blanking,
// timing delay, border backdrop and mid-tile reset. Expected values are hand-computed.
// VRAM is modelled as a byte array answering one cycle after each read tick.
module tb_vdp_fsm;

`ifdef VDP_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        pxclk = 1'b0;
  logic        reset;
  logic [9:0]  px_row;
  logic [2:0]  vdp_mode;
  logic        vdp_blank, vdp_smag, vdp_ssiz;
  logic [3:0]  vdp_name_base;
  logic [7:0]  vdp_color_base;
  logic [2:0]  vdp_pattern_base;
  logic [6:0]  vdp_sprite_att_base;
  logic [2:0]  vdp_sprite_pat_base;
  logic [3:0]  vdp_fg_color, vdp_bg_color;
  logic [12:0] vdp_dma_addr;
  logic        vdp_dma_rd_tick;
  logic [7:0]  vram_dout = 8'h00;
  logic        hsync, vsync, vid_active, bdr_active, last_pixel, col_last, row_last;
  logic        hsync_out, vsync_out, vid_active_out, bdr_active_out;
  logic        last_pixel_out, col_last_out, row_last_out;
  logic [3:0]  color_out;

  logic [7:0]  vram [0:8191];
  int          checks = 0;
  int          failures = 0;
  logic [3:0]  seq1 [8];
  logic [3:0]  seq2 [8];

  always #5 pxclk = ~pxclk;

  always @(posedge pxclk) if (vdp_dma_rd_tick) vram_dout <= vram[vdp_dma_addr];

  vdp_fsm dut (
    .pxclk(pxclk), .reset(reset), .px_row(px_row), .vdp_mode(vdp_mode),
    .vdp_blank(vdp_blank), .vdp_smag(vdp_smag), .vdp_ssiz(vdp_ssiz),
    .vdp_name_base(vdp_name_base), .vdp_color_base(vdp_color_base),
    .vdp_pattern_base(vdp_pattern_base), .vdp_sprite_att_base(vdp_sprite_att_base),
    .vdp_sprite_pat_base(vdp_sprite_pat_base), .vdp_fg_color(vdp_fg_color),
    .vdp_bg_color(vdp_bg_color), .vdp_dma_addr(vdp_dma_addr),
    .vdp_dma_rd_tick(vdp_dma_rd_tick), .vram_dout(vram_dout),
    .hsync(hsync), .vsync(vsync), .vid_active(vid_active), .bdr_active(bdr_active),
    .last_pixel(last_pixel), .col_last(col_last), .row_last(row_last),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .vid_active_out(vid_active_out),
    .bdr_active_out(bdr_active_out), .last_pixel_out(last_pixel_out),
    .col_last_out(col_last_out), .row_last_out(row_last_out), .color_out(color_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge pxclk);
    #1;
  endtask

  function automatic logic [3:0] tr(input logic [3:0] n, input logic [3:0] bg);
    return (TRANSP && n == 4'd0) ? bg : n;
  endfunction

  initial begin
    for (int k = 0; k < 8192; k++) vram[k] = 8'h00;
    vram[13'h0801] = 8'h81;  vram[13'h0408] = 8'h85;  vram[13'h0C10] = 8'h34;
    vram[13'h0802] = 8'h18;  vram[13'h00C5] = 8'hAA;  vram[13'h0C03] = 8'hF0;

    reset = 1'b0; px_row = '0; vdp_mode = 3'd1; vdp_blank = 1'b0;
    vdp_smag = 1'b0; vdp_ssiz = 1'b0; vdp_name_base = 4'd2; vdp_color_base = 8'h30;
    vdp_pattern_base = 3'd0; vdp_sprite_att_base = '0; vdp_sprite_pat_base = '0;
    vdp_fg_color = 4'd0; vdp_bg_color = 4'd2;
    hsync = 0; vsync = 0; vid_active = 0; bdr_active = 0; last_pixel = 0; col_last = 0; row_last = 0;

    // Reset state
    repeat (3) cyc();
    chk("rst_color", color_out, 0);
    chk("rst_tick", vdp_dma_rd_tick, 0);
    chk("rst_addr", vdp_dma_addr, 0);
    chk("rst_hsync_out", hsync_out, 0);
    chk("rst_vid_out", vid_active_out, 0);
    reset = 1'b1;
    repeat (10) cyc();
    chk("idle_color", color_out, 0);
    chk("idle_tick", vdp_dma_rd_tick, 0);

    // Three tiles of active video (tiles 0,1,2), row 5 from tile 2 onward
    for (int k = 0; k < 8; k++) begin
      seq1[k] = (8'h85 >> (7 - k)) & 1 ? 4'd3 : 4'd4;
      seq2[k] = (8'hAA >> (7 - k)) & 1 ? 4'd15 : 4'd0;
    end
    for (int i = 0; i <= 34; i++) begin
      vid_active = (i < 24);
      px_row = (i >= 16) ? 10'd5 : 10'd0;
      #1;
      if (i == 1)  begin chk("t0_name_tick", vdp_dma_rd_tick, 1); chk("t0_name_addr", vdp_dma_addr, 13'h0800); end
      if (i == 9)  begin chk("t1_name_tick", vdp_dma_rd_tick, 1); chk("t1_name_addr", vdp_dma_addr, 13'h0801); end
      if (i == 10) begin chk("t1_cpu_tick", vdp_dma_rd_tick, 0); chk("t1_hold_addr", vdp_dma_addr, 13'h0801); end
      if (i == 11) begin chk("t1_pat_tick", vdp_dma_rd_tick, 1); chk("t1_pat_addr", vdp_dma_addr, 13'h0408); end
      if (i == 12) begin chk("t1_col_tick", vdp_dma_rd_tick, 1); chk("t1_col_addr", vdp_dma_addr, 13'h0C10); end
      if (i == 13) chk("t1_col_ld_tick", vdp_dma_rd_tick, 0);
      if (i == 17) chk("t2_name_addr", vdp_dma_addr, 13'h0802);
      if (i == 19) chk("t2_pat_addr", vdp_dma_addr, 13'h00C5);
      if (i == 20) chk("t2_col_addr", vdp_dma_addr, 13'h0C03);
      if (i == 8)  begin chk("pre_color", color_out, 0); chk("pre_vid_out", vid_active_out, 0); end
      if (i == 9)  chk("first_vid_out", vid_active_out, 1);
      if (i >= 9 && i <= 16)  chk($sformatf("t0_px%0d", i - 9), color_out, tr(4'd0, 4'd2));
      if (i >= 17 && i <= 24) chk($sformatf("t1_px%0d", i - 17), color_out, seq1[i-17]);
      if (i >= 25 && i <= 32) chk($sformatf("t2_px%0d", i - 25), color_out, tr(seq2[i-25], 4'd2));
      if (i == 33) begin chk("post_color", color_out, 0); chk("post_vid_out", vid_active_out, 0); end
      cyc();
    end

    // Blanked active video: no reads, backdrop colour; reset asserted at ring slot 0x10
    vdp_blank = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      vid_active = 1'b1;
      #1;
      chk($sformatf("blank_tick%0d", i), vdp_dma_rd_tick, 0);
      if (i >= 9) chk($sformatf("blank_color%0d", i), color_out, 4'd2);
      if (i == 19) chk("blank_vid_out", vid_active_out, 1);
      if (i == 20) begin
        reset = 1'b0;
        #1;
        chk("mid_rst_color", color_out, 0);
        chk("mid_rst_vid_out", vid_active_out, 0);
        chk("mid_rst_addr", vdp_dma_addr, 0);
        chk("mid_rst_tick", vdp_dma_rd_tick, 0);
      end
      if (i < 20) cyc();
    end
    cyc();
    vid_active = 1'b0; vdp_blank = 1'b0; px_row = '0;
    cyc();
    reset = 1'b1;
    repeat (3) cyc();

    // Fetch resumes aligned to the next vid_active rise
    for (int i = 0; i <= 8; i++) begin
      vid_active = 1'b1;
      #1;
      if (i == 0) chk("resume_idle_tick", vdp_dma_rd_tick, 0);
      if (i == 1) begin chk("resume_tick", vdp_dma_rd_tick, 1); chk("resume_addr", vdp_dma_addr, 13'h0800); end
      if (i == 4) begin chk("resume_col_tick", vdp_dma_rd_tick, 1); chk("resume_col_addr", vdp_dma_addr, 13'h0C00); end
      cyc();
    end
    vid_active = 1'b0;
    repeat (12) cyc();

    // Timing pulse delay and border backdrop
    for (int i = 0; i <= 16; i++) begin
      hsync = (i == 0);
      last_pixel = (i == 0);
      bdr_active = (i >= 2 && i <= 5);
      #1;
      if (i >= 7 && i <= 11) begin
        chk($sformatf("hsync_out%0d", i), hsync_out, (i == 9));
        chk($sformatf("last_pixel_out%0d", i), last_pixel_out, (i == 9));
      end
      if (i >= 10 && i <= 15) chk($sformatf("bdr_color%0d", i), color_out, (i >= 11 && i <= 14) ? 4'd2 : 4'd0);
      if (i == 11) chk("bdr_active_out", bdr_active_out, 1);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
